// File: rtl/fetch_group_frontend_pkg.sv
// Shared definitions for the fetch-group frontend.
// Contents: exception codes, the reset PC default, the metadata stage
// record carried alongside instruction memory data, and a lane-count helper.
package fetch_group_frontend_pkg;

    // Widest supported fetch group; narrower groups leave upper mask bits at 0.
    localparam int MAX_FETCH_W = 4;

    localparam logic [31:0] RESET_PC_DEFAULT  = 32'h0000_0400;
    localparam logic [7:0]  EXC_NONE          = 8'h00;
    localparam logic [7:0]  EXC_MISALIGNED_PC = 8'h84;

    // One metadata pipeline entry: lane mask, exact PC of the first valid
    // lane, slot id of the first valid lane, and group exception code.
    typedef struct packed {
        logic [MAX_FETCH_W-1:0] mask;
        logic [31:0]            pc;
        logic [31:0]            slot_id;
        logic [7:0]             exc;
    } meta_t;

    // Number of valid lanes in a mask, widened to the slot id width.
    function automatic logic [31:0] lane_count(input logic [MAX_FETCH_W-1:0] m);
        logic [31:0] n;
        n = 32'd0;
        for (int i = 0; i < MAX_FETCH_W; i++) begin
            n = n + {31'd0, m[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/fetch_group_frontend_if.sv
// Bundle of control/redirect inputs and fetch/decode outputs of the frontend.
// Signal names carry i_/o_ from the frontend's point of view.
//   slave  : the frontend itself
//   master : the environment (redirect sources, decode queue, memory, bench)
interface fetch_group_frontend_if #(
    parameter int FETCH_W = 2
);
    logic                i_clk_en;
    logic                i_stall;
    logic                i_branch;
    logic [31:0]         i_branch_tgt;
    logic                i_interrupt;
    logic [31:0]         i_interrupt_vector;
    logic                i_rfe_in_wb;
    logic [31:0]         i_epc;
    logic                i_flush;
    logic [7:0]          i_exc_tlb;
    logic [31:0]         o_fetch_addr;
    logic                o_fetch_req;
    logic [FETCH_W-1:0]  o_out_valid;
    logic [31:0]         o_out_pc;
    logic [31:0]         o_out_slot_id;
    logic [7:0]          o_out_exc;

    modport slave (
        input  i_clk_en, i_stall, i_branch, i_branch_tgt, i_interrupt,
               i_interrupt_vector, i_rfe_in_wb, i_epc, i_flush, i_exc_tlb,
        output o_fetch_addr, o_fetch_req, o_out_valid, o_out_pc,
               o_out_slot_id, o_out_exc
    );

    modport master (
        output i_clk_en, i_stall, i_branch, i_branch_tgt, i_interrupt,
               i_interrupt_vector, i_rfe_in_wb, i_epc, i_flush, i_exc_tlb,
        input  o_fetch_addr, o_fetch_req, o_out_valid, o_out_pc,
               o_out_slot_id, o_out_exc
    );
endinterface

// File: rtl/fetch_group_frontend_meta_stage.sv
// fetch_meta_stage: one register of the fetch metadata pipe.
// Ports: clk, rst (sync, active-high), i_en (advance), i_flush (kill mask),
//        i_exc_tlb (TLB exception, used only when MERGE_EXC is set),
//        i_d (previous stage record), o_q (this stage record).
module fetch_meta_stage
    import fetch_group_frontend_pkg::*;
#(
    parameter bit          MERGE_EXC = 1'b0,
    parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_en,
    input  logic       i_flush,
    input  logic [7:0] i_exc_tlb,
    input  meta_t      i_d,
    output meta_t      o_q
);
    meta_t r_q;
    meta_t w_nxt;

    // Next record: flush kills the mask; the merge stage attaches the TLB
    // exception only to a real group that has no earlier exception.
    always_comb begin
        w_nxt = i_d;
        if (i_flush) begin
            w_nxt.mask = '0;
        end else begin
            w_nxt.mask = i_d.mask;
        end
        if (MERGE_EXC && (i_d.exc == EXC_NONE)) begin
            if (i_d.mask != '0) begin
                w_nxt.exc = i_exc_tlb;
            end else begin
                w_nxt.exc = EXC_NONE;
            end
        end else begin
            w_nxt.exc = i_d.exc;
        end
    end

    // Stage register; holds whenever the frontend is not enabled.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_q <= '{mask: '0, pc: RESET_PC, slot_id: 32'd0, exc: EXC_NONE};
        end else if (i_en) begin
            r_q <= w_nxt;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/fetch_group_frontend.sv
// fetch_group_frontend: block-aligned group fetch address generation with
// redirect/stall priority, plus a MEM_LAT-deep metadata pipe that keeps lane
// masks, PCs, slot ids and exceptions aligned with instruction memory data.
// Ports: clk, rst (sync, active-high), fg (slave side of the frontend bus:
//        redirects, stall, flush, TLB exception in; fetch address/request and
//        decode-side group metadata out).
module fetch_group_frontend
    import fetch_group_frontend_pkg::*;
#(
    parameter int          FETCH_W  = 2,
    parameter int          MEM_LAT  = 2,
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst,
    fetch_group_frontend_if.slave fg
);
    localparam logic [31:0] GROUP_BYTES = 32'(FETCH_W * 4);
    localparam logic [31:0] OFFSET_MASK = GROUP_BYTES - 32'd1;
    localparam logic [31:0] LANE_MASK   = 32'(FETCH_W - 1);

    logic [31:0]            r_pc;
    logic [31:0]            r_slot_seq;
    meta_t                  r_s0;
    logic [31:0]            w_base;
    logic [31:0]            w_lane;
    logic                   w_misaligned;
    logic [MAX_FETCH_W-1:0] w_issue_mask;
    logic [7:0]             w_issue_exc;
    logic                   w_issue_stop;
    logic                   w_issue;
    logic [31:0]            w_pc_nxt;
    logic [31:0]            w_slot_nxt;
    meta_t                  w_s0_nxt;
    meta_t                  w_stage [MEM_LAT+1];
    logic                   w_unused_mask;

    // Group decode of the current pc: a misaligned pc fetches only its own
    // lane, an aligned pc fetches from its lane to the end of the group.
    always_comb begin
        w_base       = r_pc & ~OFFSET_MASK;
        w_lane       = (r_pc >> 2) & LANE_MASK;
        w_misaligned = (r_pc[1:0] != 2'b00);
        w_issue_exc  = w_misaligned ? EXC_MISALIGNED_PC : EXC_NONE;
        w_issue_mask = '0;
        for (int i = 0; i < MAX_FETCH_W; i++) begin
            if (i >= FETCH_W) begin
                w_issue_mask[i] = 1'b0;
            end else if (w_misaligned) begin
                w_issue_mask[i] = (32'(i) == w_lane);
            end else begin
                w_issue_mask[i] = (32'(i) >= w_lane);
            end
        end
    end

    // Redirect/stall priority; every non-issue case loads a bubble that
    // still records the pre-update pc and slot sequence.
    always_comb begin
        w_issue_stop = fg.i_stall && !fg.i_interrupt && !fg.i_rfe_in_wb;
        w_issue      = 1'b0;
        w_pc_nxt     = r_pc;
        w_slot_nxt   = r_slot_seq;
        w_s0_nxt     = '{mask: '0, pc: r_pc, slot_id: r_slot_seq, exc: EXC_NONE};
        if (fg.i_interrupt) begin
            w_pc_nxt = fg.i_interrupt_vector;
        end else if (fg.i_rfe_in_wb) begin
            w_pc_nxt = fg.i_epc;
        end else if (fg.i_branch) begin
            w_pc_nxt = fg.i_branch_tgt;
        end else if (w_issue_stop) begin
            w_pc_nxt = r_pc;
        end else begin
            w_issue        = 1'b1;
            w_s0_nxt.mask  = w_issue_mask;
            w_s0_nxt.exc   = w_issue_exc;
            w_pc_nxt       = w_base + GROUP_BYTES;
            w_slot_nxt     = r_slot_seq + lane_count(w_issue_mask);
        end
    end

    // PC, slot sequence and issue register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc       <= RESET_PC;
            r_slot_seq <= 32'd0;
            r_s0       <= '{mask: '0, pc: RESET_PC, slot_id: 32'd0, exc: EXC_NONE};
        end else if (fg.i_clk_en) begin
            r_pc       <= w_pc_nxt;
            r_slot_seq <= w_slot_nxt;
            r_s0       <= w_s0_nxt;
        end
    end

    assign w_stage[0] = r_s0;

    // Metadata pipe; only the first stage sees the TLB exception.
    for (genvar k = 1; k <= MEM_LAT; k++) begin : g_meta
        fetch_meta_stage #(
            .MERGE_EXC (k == 1),
            .RESET_PC  (RESET_PC)
        ) u_stage (
            .clk       (clk),
            .rst       (rst),
            .i_en      (fg.i_clk_en),
            .i_flush   (fg.i_flush),
            .i_exc_tlb (fg.i_exc_tlb),
            .i_d       (w_stage[k-1]),
            .o_q       (w_stage[k])
        );
    end

    assign fg.o_fetch_addr  = r_pc & ~OFFSET_MASK;
    assign fg.o_fetch_req   = !rst && fg.i_clk_en && w_issue;
    assign fg.o_out_valid   = w_stage[MEM_LAT].mask[FETCH_W-1:0];
    assign fg.o_out_pc      = w_stage[MEM_LAT].pc;
    assign fg.o_out_slot_id = w_stage[MEM_LAT].slot_id;
    assign fg.o_out_exc     = w_stage[MEM_LAT].exc;
    // Lanes above FETCH_W are structurally zero.
    assign w_unused_mask    = |w_stage[MEM_LAT].mask;

endmodule
